// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct encodings, PC-select codes and FSM states for the
// fetch/decode-execute sequencing controller.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JUMP  = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_MUL   = 6'b011000;

  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'd0,
    PCSEL_BRANCH = 2'd1,
    PCSEL_JUMP   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MUL_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  function automatic logic is_mul(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_MUL);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall and retired-instruction performance counters with synchronous clear.
// Both counters wrap modulo 2^CNT_W.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             stall_inc_i,
  input  logic             retire_inc_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  always_comb begin
    stall_d  = stall_q + CNT_W'(stall_inc_i);
    retire_d = retire_q + CNT_W'(retire_inc_i);
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      stall_q  <= '0;
      retire_q <= '0;
    end else begin
      stall_q  <= stall_d;
      retire_q <= retire_d;
    end
  end

  assign stall_cnt_o  = stall_q;
  assign retire_cnt_o = retire_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the two-stage fetch/decode-execute pipeline:
// PC/fetch-latch enables, branch/jump flush, multiply stall, HALT, perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       dec_opcode,
  input  logic [5:0]       dec_funct,
  input  logic             alu_zero,
  input  logic             stall_i,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             wb_en,
  output logic             retire_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  // mul_cnt counts the remaining wait cycles after the first multiply cycle.
  localparam int              MC_W     = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [MC_W-1:0] MUL_LOAD = (MUL_LAT > 2) ? MC_W'(MUL_LAT - 2) : '0;

  state_e          state_q, state_d;
  logic            dec_valid_q, dec_valid_d;
  logic [MC_W-1:0] mul_cnt_q, mul_cnt_d;
  logic            stall_inc;
  logic            dec_mul;

  assign dec_mul = is_mul(dec_opcode, dec_funct) && (MUL_LAT > 1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    pc_en      = 1'b0;
    pc_sel     = PCSEL_SEQ;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    wb_en      = 1'b0;
    retire_o   = 1'b0;
    stall_inc  = 1'b0;
    state_d    = state_q;
    mul_cnt_d  = mul_cnt_q;

    if (rst) begin
      ifid_flush = 1'b1;
    end else if (stall_i) begin
      stall_inc = (state_q == ST_RUN) || (state_q == ST_MUL_WAIT);
    end else begin
      case (state_q)
        ST_FILL: begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!dec_valid_q) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end else if (dec_mul) begin
            stall_inc = 1'b1;
            mul_cnt_d = MUL_LOAD;
            state_d   = ST_MUL_WAIT;
          end else begin
            case (dec_opcode)
              OP_BEQ: begin
                retire_o = 1'b1;
                pc_en    = 1'b1;
                if (alu_zero) begin
                  pc_sel     = PCSEL_BRANCH;
                  ifid_flush = 1'b1;
                end else begin
                  ifid_en = 1'b1;
                end
              end
              OP_JUMP: begin
                retire_o   = 1'b1;
                pc_en      = 1'b1;
                pc_sel     = PCSEL_JUMP;
                ifid_flush = 1'b1;
              end
              OP_HALT: begin
                retire_o = 1'b1;
                state_d  = ST_HALT;
              end
              default: begin
                retire_o = 1'b1;
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                wb_en    = 1'b1;
              end
            endcase
          end
        end
        ST_MUL_WAIT: begin
          if (mul_cnt_q != '0) begin
            stall_inc = 1'b1;
            mul_cnt_d = mul_cnt_q - MC_W'(1);
          end else begin
            retire_o = 1'b1;
            wb_en    = 1'b1;
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            state_d  = ST_RUN;
          end
        end
        ST_HALT: ;
        default: state_d = ST_FILL;
      endcase
    end
  end

  // A flush always wins over a load; a stalled latch keeps its contents.
  always_comb begin
    dec_valid_d = dec_valid_q;
    if (ifid_flush)   dec_valid_d = 1'b0;
    else if (ifid_en) dec_valid_d = 1'b1;
  end

  assign halted_o = (state_q == ST_HALT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      dec_valid_q <= 1'b0;
      mul_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      dec_valid_q <= dec_valid_d;
      mul_cnt_q   <= mul_cnt_d;
    end
  end

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .clr_i        (rst),
    .stall_inc_i  (stall_inc),
    .retire_inc_i (retire_o),
    .stall_cnt_o  (stall_cnt),
    .retire_cnt_o (retire_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: two controllers (MUL_LAT=4/CNT_W=32 and MUL_LAT=1/CNT_W=4)
// driven by a directed program followed by random instruction streams.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NCYC = 4000;

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        wb_en;
    logic        retire;
    logic        halted;
    logic [1:0]  pc_sel;
    logic        chk_ifid;
    logic        chk_cnt;
    logic [31:0] scnt;
    logic [31:0] rcnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [2];
  logic [5:0] op_v    [2];
  logic [5:0] fn_v    [2];
  logic       zero_v  [2];
  logic       stall_v [2];
  logic       pc_en_v [2];
  logic [1:0] pc_sel_v[2];
  logic       ifid_en_v[2];
  logic       flush_v [2];
  logic       wb_en_v [2];
  logic       retire_v[2];
  logic       halted_v[2];
  logic [31:0] scnt_a, rcnt_a;
  logic [3:0]  scnt_b, rcnt_b;

  pipeline_ctrl #(.MUL_LAT(4), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst_v[0]), .dec_opcode(op_v[0]), .dec_funct(fn_v[0]),
    .alu_zero(zero_v[0]), .stall_i(stall_v[0]), .pc_en(pc_en_v[0]),
    .pc_sel(pc_sel_v[0]), .ifid_en(ifid_en_v[0]), .ifid_flush(flush_v[0]),
    .wb_en(wb_en_v[0]), .retire_o(retire_v[0]), .halted_o(halted_v[0]),
    .stall_cnt(scnt_a), .retire_cnt(rcnt_a)
  );

  pipeline_ctrl #(.MUL_LAT(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst_v[1]), .dec_opcode(op_v[1]), .dec_funct(fn_v[1]),
    .alu_zero(zero_v[1]), .stall_i(stall_v[1]), .pc_en(pc_en_v[1]),
    .pc_sel(pc_sel_v[1]), .ifid_en(ifid_en_v[1]), .ifid_flush(flush_v[1]),
    .wb_en(wb_en_v[1]), .retire_o(retire_v[1]), .halted_o(halted_v[1]),
    .stall_cnt(scnt_b), .retire_cnt(rcnt_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;
  exp_t sb0[$];
  exp_t sb1[$];

  // Reference model: what sits in decode, how long it has been there, and
  // whether the machine is filling or halted.
  bit          m_fill [2];
  bit          m_halt [2];
  bit          m_valid[2];
  int          m_age  [2];
  int          m_hcyc [2];
  int          prog_idx[2];
  int unsigned m_scnt [2];
  int unsigned m_rcnt [2];
  logic [5:0]  cur_op [2];
  logic [5:0]  cur_fn [2];
  logic [11:0] prog   [10];

  function automatic int mlat(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [11:0] rand_instr();
    int r;
    r = $urandom_range(31);
    if (r < 4)       return {OP_ORI, 6'($urandom)};
    else if (r < 6)  return {OP_LW, 6'($urandom)};
    else if (r < 8)  return {OP_SW, 6'($urandom)};
    else if (r < 11) return {OP_RTYPE, 6'($urandom)};
    else if (r < 16) return {OP_RTYPE, FN_MUL};
    else if (r < 20) return {OP_BEQ, 6'($urandom)};
    else if (r < 22) return {OP_JUMP, 6'($urandom)};
    else if (r == 22) return {OP_HALT, 6'($urandom)};
    else             return {6'($urandom), 6'($urandom)};
  endfunction

  task automatic load_next(input int i);
    logic [11:0] ins;
    if (prog_idx[i] < 10) begin
      ins = prog[prog_idx[i]];
      prog_idx[i]++;
    end else begin
      ins = rand_instr();
    end
    cur_op[i] = ins[11:6];
    cur_fn[i] = ins[5:0];
  endtask

  // Choose inputs for one cycle, push the expected outputs, advance the model.
  task automatic step(input int i);
    exp_t e;
    logic r, s, z;
    logic [5:0] op, fn;
    bit ld, mul;
    r = (cyc < 2) || (m_halt[i] && m_hcyc[i] >= 10);
    if (!r && cyc > 200) begin
      if (m_valid[i] && m_age[i] == 2 && is_mul(cur_op[i], cur_fn[i]))
        r = ($urandom_range(4) == 0);
      else
        r = ($urandom_range(199) == 0);
    end
    s  = !r && !m_fill[i] && ($urandom_range(99) < 15);
    z  = 1'($urandom_range(1));
    op = m_valid[i] ? cur_op[i] : 6'($urandom);
    fn = m_valid[i] ? cur_fn[i] : 6'($urandom);
    rst_v[i] = r; stall_v[i] = s; zero_v[i] = z; op_v[i] = op; fn_v[i] = fn;

    e = '0;
    e.chk_cnt  = !r;
    e.chk_ifid = 1'b1;
    e.halted   = m_halt[i] && !r;
    e.scnt     = m_scnt[i];
    e.rcnt     = m_rcnt[i];
    ld = 1'b0;
    if (r) begin
      e.ifid_flush = 1'b1;
      m_fill[i] = 1'b1; m_halt[i] = 1'b0; m_valid[i] = 1'b0;
      m_age[i] = 0; m_hcyc[i] = 0; m_scnt[i] = 0; m_rcnt[i] = 0;
    end else if (s) begin
      if (!m_fill[i] && !m_halt[i]) m_scnt[i]++;
    end else if (m_halt[i]) begin
      m_hcyc[i]++;
    end else if (m_fill[i] || !m_valid[i]) begin
      e.pc_en = 1'b1; e.ifid_en = 1'b1;
      m_fill[i] = 1'b0;
      ld = 1'b1;
    end else begin
      mul = is_mul(op, fn);
      if (mul && mlat(i) > 1 && m_age[i] < mlat(i) - 1) begin
        m_age[i]++;
        m_scnt[i]++;
      end else if (op == OP_BEQ && z) begin
        e.pc_sel = PCSEL_BRANCH; e.pc_en = 1'b1; e.ifid_flush = 1'b1;
        e.retire = 1'b1; e.chk_ifid = 1'b0;
        m_valid[i] = 1'b0;
      end else if (op == OP_JUMP) begin
        e.pc_sel = PCSEL_JUMP; e.pc_en = 1'b1; e.ifid_flush = 1'b1;
        e.retire = 1'b1; e.chk_ifid = 1'b0;
        m_valid[i] = 1'b0;
      end else if (op == OP_HALT) begin
        e.retire = 1'b1;
        m_halt[i] = 1'b1;
      end else begin
        e.pc_en = 1'b1; e.ifid_en = 1'b1; e.retire = 1'b1;
        e.wb_en = (op != OP_BEQ);
        ld = 1'b1;
      end
      if (e.retire) m_rcnt[i]++;
    end
    if (ld) begin
      m_valid[i] = 1'b1;
      m_age[i] = 0;
      load_next(i);
    end
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    started = 1'b1;
  endtask

  task automatic check(input int i, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic compare(input int i, input exp_t e);
    logic [31:0] msk, sa, ra;
    msk = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    sa  = (i == 0) ? scnt_a : {28'd0, scnt_b};
    ra  = (i == 0) ? rcnt_a : {28'd0, rcnt_b};
    check(i, "pc_en",      32'(pc_en_v[i]),  32'(e.pc_en));
    check(i, "pc_sel",     32'(pc_sel_v[i]), 32'(e.pc_sel));
    check(i, "ifid_flush", 32'(flush_v[i]),  32'(e.ifid_flush));
    check(i, "wb_en",      32'(wb_en_v[i]),  32'(e.wb_en));
    check(i, "retire_o",   32'(retire_v[i]), 32'(e.retire));
    check(i, "halted_o",   32'(halted_v[i]), 32'(e.halted));
    if (e.chk_ifid) check(i, "ifid_en", 32'(ifid_en_v[i]), 32'(e.ifid_en));
    if (e.chk_cnt) begin
      check(i, "stall_cnt",  sa, e.scnt & msk);
      check(i, "retire_cnt", ra, e.rcnt & msk);
    end
  endtask

  // Monitor: pops one expectation per instance each cycle, away from the edge.
  always @(negedge clk) begin
    if (sb0.size() > 0) compare(0, sb0.pop_front());
    else if (started) begin
      checks++; errors++;
      $display("FAIL sb_empty inst0 t=%0t: got none expected entry", $time);
    end
    if (sb1.size() > 0) compare(1, sb1.pop_front());
    else if (started) begin
      checks++; errors++;
      $display("FAIL sb_empty inst1 t=%0t: got none expected entry", $time);
    end
  end

  initial begin
    prog = '{{OP_ORI, 6'd0}, {OP_ORI, 6'd1}, {OP_ORI, 6'd2},
             {OP_BEQ, 6'd0}, {OP_BEQ, 6'd0}, {OP_RTYPE, FN_MUL},
             {OP_ORI, 6'd3}, {OP_JUMP, 6'd0}, {OP_SW, 6'd0},
             {OP_HALT, 6'd0}};
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; stall_v[i] = 1'b0; zero_v[i] = 1'b0;
      op_v[i] = '0; fn_v[i] = '0;
      m_fill[i] = 1'b1; m_halt[i] = 1'b0; m_valid[i] = 1'b0;
      m_age[i] = 0; m_hcyc[i] = 0; prog_idx[i] = 0;
      m_scnt[i] = 0; m_rcnt[i] = 0; cur_op[i] = '0; cur_fn[i] = '0;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      step(0);
      step(1);
      cyc++;
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
